keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_if.sv | 32 +++
 rtl/keypad_scanner.sv | 221 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// ============================================================================
// Module : keypad_scanner_if
// Brief  : Consumer-side key event port of the keypad scanner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_down;
    logic       overflow;

    modport master (
        output key_code,
        output key_valid,
        output key_down,
        output overflow,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_down,
        input  overflow,
        output key_ready
    );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module : keypad_scanner
// Brief  : 4x4 active-low matrix scanner with frame debounce and key holding register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module keypad_scanner #(
    parameter int ROW_PERIOD      = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    output logic [3:0]       row_n,
    input  wire logic [3:0]  col_n,
    keypad_scanner_if.master kif
);

    localparam int                 c_CNT_W    = (ROW_PERIOD > 1) ? $clog2(ROW_PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_ROW_LAST = c_CNT_W'(ROW_PERIOD - 1);
    localparam logic [3:0]         c_DB       = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_t;

    logic [3:0]         r_col_meta;
    logic [3:0]         r_col_sync;
    logic [c_CNT_W-1:0] r_row_cnt;
    logic [1:0]         r_row_idx;
    logic [1:0]         r_acc_cnt;
    logic [3:0]         r_acc_code;
    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_next;
    logic [3:0]         r_cand;
    logic [3:0]         w_cand_next;
    logic               r_key_down;
    logic               w_key_down_next;
    logic               w_press_evt;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_overflow;

    logic               w_row_last;
    logic               w_frame_end;
    logic [3:0]         w_hits;
    logic [1:0]         w_first_col;
    logic [2:0]         w_row_pts;
    logic [2:0]         w_sum;
    logic [1:0]         w_acc_cnt_next;
    logic [3:0]         w_acc_code_next;
    logic               w_none;
    logic               w_single;
    logic               w_match;
    logic               w_pop;

    assign row_n       = ~(4'b0001 << r_row_idx);
    assign w_row_last  = (r_row_cnt == c_ROW_LAST);
    assign w_frame_end = w_row_last && (r_row_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta <= 4'hF;
            r_col_sync <= 4'hF;
        end else begin
            r_col_meta <= col_n;
            r_col_sync <= r_col_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt <= '0;
            r_row_idx <= 2'd0;
        end else if (w_row_last) begin
            r_row_cnt <= '0;
            r_row_idx <= r_row_idx + 2'd1;
        end else begin
            r_row_cnt <= r_row_cnt + 1'b1;
        end
    end

    // Merge this row's hits into the frame: saturating point count, first code found.
    always_comb begin
        w_hits      = ~r_col_sync;
        w_first_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_hits[i]) w_first_col = 2'(i);
        end
        w_row_pts       = 3'(w_hits[0]) + 3'(w_hits[1]) + 3'(w_hits[2]) + 3'(w_hits[3]);
        w_sum           = {1'b0, r_acc_cnt} + w_row_pts;
        w_acc_cnt_next  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_acc_code_next = ((r_acc_cnt == 2'd0) && (|w_hits)) ? {r_row_idx, w_first_col} : r_acc_code;
    end

    always_ff @(posedge clk) begin
        if (rst || (w_frame_end)) begin
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_row_last) begin
            r_acc_cnt  <= w_acc_cnt_next;
            r_acc_code <= w_acc_code_next;
        end
    end

    assign w_none   = (w_acc_cnt_next == 2'd0);
    assign w_single = (w_acc_cnt_next == 2'd1);
    assign w_match  = w_single && (w_acc_code_next == r_cand);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_cand     <= 4'd0;
            r_key_down <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cand     <= w_cand_next;
            r_key_down <= w_key_down_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_cand_next     = r_cand;
        w_key_down_next = r_key_down;
        w_press_evt     = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        w_cand_next = w_acc_code_next;
                        if (c_DB == 4'd1) begin
                            w_press_evt     = 1'b1;
                            w_key_down_next = 1'b1;
                            w_cnt_next      = 4'd0;
                            w_state_next    = ST_HELD;
                        end else begin
                            w_cnt_next   = 4'd1;
                            w_state_next = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (w_match && ((r_cnt + 4'd1) == c_DB)) begin
                        w_press_evt     = 1'b1;
                        w_key_down_next = 1'b1;
                        w_cnt_next      = 4'd0;
                        w_state_next    = ST_HELD;
                    end else if (w_match) begin
                        w_cnt_next = r_cnt + 4'd1;
                    end else begin
                        w_cnt_next   = 4'd0;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (!w_match) begin
                        if (w_none && (c_DB == 4'd1)) begin
                            w_key_down_next = 1'b0;
                            w_cnt_next      = 4'd0;
                            w_state_next    = ST_IDLE;
                        end else begin
                            w_cnt_next   = w_none ? 4'd1 : 4'd0;
                            w_state_next = ST_REL_DB;
                        end
                    end
                end
                default: begin
                    if (w_none && ((r_cnt + 4'd1) == c_DB)) begin
                        w_key_down_next = 1'b0;
                        w_cnt_next      = 4'd0;
                        w_state_next    = ST_IDLE;
                    end else if (w_none) begin
                        w_cnt_next = r_cnt + 4'd1;
                    end else if (w_match) begin
                        w_cnt_next   = 4'd0;
                        w_state_next = ST_HELD;
                    end else begin
                        w_cnt_next = 4'd0;
                    end
                end
            endcase
        end
    end

    // A press arriving while an unconsumed code is held is dropped and flagged.
    assign w_pop = r_key_valid & kif.key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_press_evt) begin
            if (!r_key_valid || w_pop) begin
                r_key_code  <= w_cand_next;
                r_key_valid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (w_pop) begin
            r_key_valid <= 1'b0;
        end
    end

    assign kif.key_code  = r_key_code;
    assign kif.key_valid = r_key_valid;
    assign kif.key_down  = r_key_down;
    assign kif.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module : tb_keypad_scanner
// Brief  : Matrix-model bench comparing the scanner against a frame-level key model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int ROW_PERIOD      = 4;
    localparam int DEBOUNCE_FRAMES = 2;
    localparam int FRAME           = 4 * ROW_PERIOD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] pressed = 16'h0;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .ROW_PERIOD      (ROW_PERIOD),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .row_n (row_n),
        .col_n (col_n),
        .kif   (kif.master)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed switch shorts its column to a row driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    int          n_err = 0;
    int          n_chk = 0;
    int          t     = 0;
    logic [15:0] fmask = 16'h0;
    logic [3:0]  m_code, m_cand;
    logic        m_valid, m_down, m_ovf;
    int          m_prun, m_rrun;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [3:0] lowest_key(input logic [15:0] m);
        logic [3:0] k = 4'd0;
        for (int i = 15; i >= 0; i--) if (m[i]) k = 4'(i);
        return k;
    endfunction

    task automatic model_reset();
        m_code = 4'd0; m_cand = 4'd0; m_valid = 1'b0; m_down = 1'b0; m_ovf = 1'b0;
        m_prun = 0; m_rrun = 0; t = 0;
    endtask

    // Effect of the clock edge that closes cycle t, given key_ready during that cycle.
    task automatic model_edge(input logic ready);
        int         n;
        logic [3:0] k;
        logic       ev, pop;
        ev = 1'b0;
        if ((t % FRAME) == FRAME - 1) begin
            n = $countones(fmask);
            k = lowest_key(fmask);
            if (!m_down) begin
                if (m_prun == 0) begin
                    if (n == 1) begin m_cand = k; m_prun = 1; end
                end else if (n == 1 && k == m_cand) begin
                    m_prun++;
                end else begin
                    m_prun = 0;
                end
                if (m_prun == DEBOUNCE_FRAMES) begin
                    ev = 1'b1; m_down = 1'b1; m_prun = 0; m_rrun = 0;
                end
            end else begin
                m_rrun = (n == 0) ? m_rrun + 1 : 0;
                if (m_rrun == DEBOUNCE_FRAMES) begin m_down = 1'b0; m_rrun = 0; end
            end
        end
        pop = m_valid & ready;
        if (ev) begin
            if (!m_valid || pop) begin m_code = m_cand; m_valid = 1'b1; end
            else m_ovf = 1'b1;
        end else if (pop) begin
            m_valid = 1'b0;
        end
    endtask

    // Called at a negedge: check outputs, drive this cycle, advance one clock.
    task automatic step(input logic ready);
        logic [3:0] exp_row;
        exp_row = ~(4'b0001 << ((t / ROW_PERIOD) % 4));
        check_val("row_n",     row_n,         exp_row);
        check_val("key_valid", kif.key_valid, m_valid);
        check_val("key_down",  kif.key_down,  m_down);
        check_val("overflow",  kif.overflow,  m_ovf);
        if (m_valid) check_val("key_code", kif.key_code, m_code);
        kif.key_ready = ready;
        if ((t % FRAME) == 0) fmask = pressed;
        model_edge(ready);
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random, 3 high on first cycle only.
    task automatic run_frame(input logic [15:0] mask, input int rmode);
        logic rdy;
        pressed = mask;
        for (int i = 0; i < FRAME; i++) begin
            case (rmode)
                0:       rdy = 1'b0;
                1:       rdy = 1'b1;
                2:       rdy = 1'($urandom % 2);
                default: rdy = (i == 0);
            endcase
            step(rdy);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        kif.key_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] mask;
        int          pick, dwell;
        kif.key_ready = 1'b0;
        @(negedge clk);
        do_reset();
        check_val("rst_row_n",  row_n,         4'b1110);
        check_val("rst_valid",  kif.key_valid, 1'b0);
        check_val("rst_code",   kif.key_code,  4'h0);

        // Idle scanning
        for (int f = 0; f < 4; f++) run_frame(16'h0, 0);
        check_val("idle_down", kif.key_down, 1'b0);

        // Single key row2/col1 -> code 9, consumed by one ready pulse, then release
        run_frame(16'h1 << 9, 0);
        run_frame(16'h1 << 9, 0);
        check_val("k9_valid", kif.key_valid, 1'b1);
        check_val("k9_code",  kif.key_code,  4'h9);
        check_val("k9_down",  kif.key_down,  1'b1);
        pressed = 16'h1 << 9;
        step(1'b1);
        check_val("k9_popped", kif.key_valid, 1'b0);
        for (int i = 1; i < FRAME; i++) step(1'b0);
        for (int f = 0; f < 3; f++) run_frame(16'h0, 0);
        check_val("k9_released", kif.key_down,  1'b0);
        check_val("k9_no_event", kif.key_valid, 1'b0);

        // Bounce on key 5
        for (int f = 0; f < 4; f++) begin
            run_frame(16'h1 << 5, 0);
            run_frame(16'h0, 0);
        end
        check_val("bounce_valid", kif.key_valid, 1'b0);
        check_val("bounce_down",  kif.key_down,  1'b0);

        // Ghosting: keys 0 and 3 together, then key 3 lifted
        for (int f = 0; f < 3; f++) run_frame(16'h0009, 0);
        check_val("multi_valid", kif.key_valid, 1'b0);
        run_frame(16'h0001, 0);
        run_frame(16'h0001, 0);
        check_val("k0_valid", kif.key_valid, 1'b1);
        check_val("k0_code",  kif.key_code,  4'h0);
        run_frame(16'h0001, 1);
        for (int f = 0; f < 3; f++) run_frame(16'h0, 1);

        // Overflow: A then B with nobody consuming
        for (int f = 0; f < 3; f++) run_frame(16'h1 << 10, 0);
        for (int f = 0; f < 3; f++) run_frame(16'h0, 0);
        for (int f = 0; f < 3; f++) run_frame(16'h1 << 11, 0);
        for (int f = 0; f < 3; f++) run_frame(16'h0, 0);
        check_val("ovf_code", kif.key_code, 4'hA);
        check_val("ovf_flag", kif.overflow, 1'b1);
        run_frame(16'h0, 1);
        check_val("ovf_drained", kif.key_valid, 1'b0);
        check_val("ovf_sticky",  kif.overflow,  1'b1);

        // Reset while a press is being debounced
        run_frame(16'h1 << 4, 0);
        for (int i = 0; i < 5; i++) step(1'b0);
        do_reset();
        check_val("mid_rst_ovf", kif.overflow, 1'b0);
        run_frame(16'h1 << 4, 0);
        check_val("mid_rst_1frame", kif.key_valid, 1'b0);
        run_frame(16'h1 << 4, 0);
        check_val("mid_rst_2frames", kif.key_valid, 1'b1);
        check_val("mid_rst_code",    kif.key_code,  4'h4);

        // Randomized key activity against the model
        for (int seg = 0; seg < 40; seg++) begin
            pick = int'($urandom % 4);
            case (pick)
                0:       mask = 16'h0;
                3:       mask = (16'h1 << ($urandom % 16)) | (16'h1 << ($urandom % 16));
                default: mask = 16'h1 << ($urandom % 16);
            endcase
            dwell = int'($urandom_range(1, 4));
            for (int f = 0; f < dwell; f++) run_frame(mask, (seg % 3 == 0) ? 0 : 2);
        end
        for (int f = 0; f < 3; f++) run_frame(16'h0, 1);
        check_val("final_down",  kif.key_down,  1'b0);
        check_val("final_valid", kif.key_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
